// File: rtl/sym_response_scorer_pkg.sv
// Shared types and constants for the symbol response scorer.
package sym_pkg;

  // Scorer FSM states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_e;

  // All segments off (the segments are active-low)
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int BCD_W   = 4;
  localparam int COUNT_W = 8;

endpackage

// File: rtl/sym_response_scorer_bcd_sat_counter.sv
// Two-digit BCD counter that saturates at 99.
// A clear and an increment in the same cycle give a count of 01.
module bcd_sat_counter
  import sym_pkg::*;
(
  input  logic               Clk100M,
  input  logic               Reset,
  input  logic               clr,
  input  logic               inc,
  output logic [COUNT_W-1:0] count
);

  logic [BCD_W-1:0] ones_q, tens_q;
  logic [BCD_W-1:0] ones_d, tens_d;
  logic [BCD_W-1:0] ones_b, tens_b;

  // Next count: apply the clear first, then a saturating BCD increment
  always_comb begin
    ones_b = clr ? '0 : ones_q;
    tens_b = clr ? '0 : tens_q;
    ones_d = ones_b;
    tens_d = tens_b;
    if (inc && !(tens_b == 4'd9 && ones_b == 4'd9)) begin
      if (ones_b == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_b + 4'd1;
      end else begin
        ones_d = ones_b + 4'd1;
      end
    end
  end

  // Digit registers
  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      ones_q <= '0;
      tens_q <= '0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign count = {tens_q, ones_q};

endmodule

// File: rtl/sym_response_scorer.sv
// Holds each generated symbol on the display for a response window and
// scores the player's press as a hit, miss or false press.
module sym_response_scorer
  import sym_pkg::*;
#(
  parameter int WINDOW_CYCLES = 50000000,
  parameter int FLASH_CYCLES  = 10000000
) (
  input  logic         Clk100M,
  input  logic         Reset,
  input  logic         gameActive,
  input  logic         generated,
  input  logic         special,
  input  logic [7:0]   generatedSym,
  input  logic         playerPress,
  output logic [7:0]   displaySeg,
  output logic         windowOpen,
  output logic         hitFlash,
  output logic [7:0]   hitCount,
  output logic [7:0]   missCount,
  output logic [7:0]   falseCount,
  output state_e       dbgState
);

  localparam int TW = $clog2(WINDOW_CYCLES);
  localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pressed_q, pressed_d;
  logic          spec_q, spec_d;
  logic [7:0]    disp_q, disp_d;
  logic          active_q;
  logic [FW-1:0] flash_cnt_q;
  logic          flash_q;
  logic          hit_inc, miss_inc, false_inc;
  logic          clr_counts;
  logic          press, responded, win_end;

  assign press      = playerPress & gameActive;
  assign clr_counts = gameActive & ~active_q;
  assign responded  = pressed_q | press;
  assign win_end    = (timer_q == TW'(WINDOW_CYCLES - 1));

  // Next-state logic: window handling and scoring events
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pressed_d = pressed_q;
    spec_d    = spec_q;
    disp_d    = disp_q;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    false_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press) false_inc = 1'b1;
        if (generated && gameActive) begin
          state_d   = ST_SHOW;
          disp_d    = generatedSym;
          spec_d    = special;
          timer_d   = '0;
          pressed_d = 1'b0;
        end
      end
      ST_SHOW: begin
        if (!gameActive) begin
          // Game ended: abandon the window without scoring a miss
          state_d   = ST_IDLE;
          disp_d    = SEG_BLANK;
          timer_d   = '0;
          pressed_d = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
          if (press && !pressed_q) begin
            if (spec_q) hit_inc = 1'b1;
            else        false_inc = 1'b1;
            pressed_d = 1'b1;
          end
          if (generated) begin
            // New symbol closes this window and opens the next one
            if (spec_q && !responded) miss_inc = 1'b1;
            disp_d    = generatedSym;
            spec_d    = special;
            timer_d   = '0;
            pressed_d = 1'b0;
          end else if (win_end) begin
            if (spec_q && !responded) miss_inc = 1'b1;
            state_d   = ST_IDLE;
            disp_d    = SEG_BLANK;
            timer_d   = '0;
            pressed_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        disp_d  = SEG_BLANK;
      end
    endcase
  end

  // FSM, window timer and display registers
  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      pressed_q <= 1'b0;
      spec_q    <= 1'b0;
      disp_q    <= SEG_BLANK;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pressed_q <= pressed_d;
      spec_q    <= spec_d;
      disp_q    <= disp_d;
      active_q  <= gameActive;
    end
  end

  // Hit flash: each hit reloads the full duration
  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      flash_q     <= 1'b0;
      flash_cnt_q <= '0;
    end else if (hit_inc) begin
      flash_q     <= 1'b1;
      flash_cnt_q <= FW'(FLASH_CYCLES - 1);
    end else if (flash_q) begin
      if (flash_cnt_q == '0) flash_q <= 1'b0;
      else                   flash_cnt_q <= flash_cnt_q - FW'(1);
    end
  end

  bcd_sat_counter u_hit (
    .Clk100M (Clk100M), .Reset (Reset), .clr (clr_counts),
    .inc (hit_inc), .count (hitCount)
  );

  bcd_sat_counter u_miss (
    .Clk100M (Clk100M), .Reset (Reset), .clr (clr_counts),
    .inc (miss_inc), .count (missCount)
  );

  bcd_sat_counter u_false (
    .Clk100M (Clk100M), .Reset (Reset), .clr (clr_counts),
    .inc (false_inc), .count (falseCount)
  );

  assign displaySeg = disp_q;
  assign windowOpen = (state_q == ST_SHOW);
  assign hitFlash   = flash_q;
  assign dbgState   = state_q;

endmodule

// File: tb/tb_sym_response_scorer.sv
// Self-checking bench for sym_response_scorer (WINDOW_CYCLES=10, FLASH_CYCLES=4).
module tb_sym_response_scorer;
  import sym_pkg::*;

  localparam int WIN   = 10;
  localparam int FLASH = 4;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       game_active = 1'b0;
  logic       generated = 1'b0;
  logic       special = 1'b0;
  logic [7:0] gen_sym = 8'h00;
  logic       player_press = 1'b0;
  logic [7:0] display_seg, hit_count, miss_count, false_count;
  logic       window_open, hit_flash;
  state_e     dbg_state;

  sym_response_scorer #(.WINDOW_CYCLES(WIN), .FLASH_CYCLES(FLASH)) dut (
    .Clk100M      (clk),
    .Reset        (rst),
    .gameActive   (game_active),
    .generated    (generated),
    .special      (special),
    .generatedSym (gen_sym),
    .playerPress  (player_press),
    .displaySeg   (display_seg),
    .windowOpen   (window_open),
    .hitFlash     (hit_flash),
    .hitCount     (hit_count),
    .missCount    (miss_count),
    .falseCount   (false_count),
    .dbgState     (dbg_state)
  );

  // Scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  logic [23:0] exp_q[$];
  int e_hit = 0, e_miss = 0, e_false = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int sat_inc(input int v);
    return (v < 99) ? v + 1 : 99;
  endfunction

  // Push the expected {hit,miss,false} after a stimulus step
  task automatic expect_counts();
    exp_q.push_back({to_bcd(e_hit), to_bcd(e_miss), to_bcd(e_false)});
  endtask

  // Pop the oldest expectation and compare it with the DUT counts
  task automatic compare_counts(input string tag);
    logic [23:0] exp;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check(tag, {8'h0, hit_count, miss_count, false_count}, {8'h0, exp});
    end
  endtask

  // Driver tasks: inputs change 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen(input logic [7:0] sym, input logic spc);
    generated = 1'b1; special = spc; gen_sym = sym;
    tick();
    generated = 1'b0; special = 1'b0;
  endtask

  task automatic press();
    player_press = 1'b1;
    tick();
    player_press = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Counts cycles until windowOpen falls, bounded
  task automatic wait_close(output int n);
    n = 0;
    while (window_open && n < 50) begin
      n++;
      tick();
    end
    if (window_open) check("window_close_timeout", 32'd1, 32'd0);
  endtask

  int n;

  initial begin
    // Reset
    rst = 1'b1;
    ticks(2);
    check("rst_disp", display_seg, 8'hFF);
    check("rst_win", window_open, 1'b0);
    check("rst_flash", hit_flash, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    expect_counts();
    compare_counts("rst_counts");
    rst = 1'b0;
    game_active = 1'b1;
    tick();

    // Hit with flash timing and window length
    gen(8'hA4, 1'b1);
    check("hit_disp", display_seg, 8'hA4);
    check("hit_win", window_open, 1'b1);
    ticks(2);
    press();
    e_hit = sat_inc(e_hit);
    expect_counts();
    compare_counts("hit_counts");
    n = 0;
    while (hit_flash && n < 20) begin
      n++;
      tick();
    end
    check("hit_flash_len", n, FLASH);
    wait_close(n);
    check("hit_disp_blank", display_seg, 8'hFF);

    // Special symbol unanswered -> miss; window is exactly WIN cycles
    gen(8'hC0, 1'b1);
    wait_close(n);
    check("miss_win_len", n, WIN);
    check("miss_win", window_open, 1'b0);
    e_miss = sat_inc(e_miss);
    expect_counts();
    compare_counts("miss_counts");

    // Non-special unanswered -> nothing
    gen(8'hF9, 1'b0);
    wait_close(n);
    expect_counts();
    compare_counts("nonspec_counts");

    // Non-special with two presses, plus one press while idle
    gen(8'h92, 1'b0);
    tick();
    press();
    tick();
    press();
    wait_close(n);
    tick();
    press();
    e_false = 2;
    expect_counts();
    compare_counts("false_counts");

    // Press on the last window cycle -> hit, not miss
    gen(8'hB0, 1'b1);
    ticks(WIN - 1);
    press();
    check("last_win", window_open, 1'b0);
    e_hit = sat_inc(e_hit);
    expect_counts();
    compare_counts("last_cycle_counts");

    // New symbol at window cycle 5 of an unpressed special window
    gen(8'h99, 1'b1);
    ticks(5);
    gen(8'h82, 1'b1);
    check("regen_disp", display_seg, 8'h82);
    check("regen_win", window_open, 1'b1);
    e_miss = sat_inc(e_miss);
    expect_counts();
    compare_counts("regen_counts");
    wait_close(n);
    check("regen_win_len", n, WIN);
    e_miss = sat_inc(e_miss);
    expect_counts();
    compare_counts("regen_close_counts");

    // Clear via gameActive toggle, then 100 hits with carry and saturation
    game_active = 1'b0;
    tick();
    game_active = 1'b1;
    tick();
    e_hit = 0; e_miss = 0; e_false = 0;
    expect_counts();
    compare_counts("toggle_clear");
    for (int i = 1; i <= 100; i++) begin
      gen(8'(i), 1'b1);
      press();
      e_hit = sat_inc(e_hit);
      if (i == 9 || i == 10 || i == 99 || i == 100) begin
        expect_counts();
        compare_counts($sformatf("hits_%0d", i));
      end
    end
    check("hits_sat_value", hit_count, 8'h99);
    wait_close(n);
    game_active = 1'b0;
    tick();
    game_active = 1'b1;
    tick();
    e_hit = 0;
    expect_counts();
    compare_counts("toggle_clear2");

    // gameActive drop mid-window: idle next cycle, no miss
    gen(8'hA4, 1'b1);
    ticks(3);
    game_active = 1'b0;
    tick();
    check("drop_win", window_open, 1'b0);
    check("drop_disp", display_seg, 8'hFF);
    check("drop_state", dbg_state, ST_IDLE);
    expect_counts();
    compare_counts("drop_counts");
    ticks(WIN + 2);
    expect_counts();
    compare_counts("drop_later_counts");
    game_active = 1'b1;
    tick();

    // Reset mid-window with a simultaneous press
    gen(8'h6D, 1'b1);
    press();
    e_hit = sat_inc(e_hit);
    expect_counts();
    compare_counts("pre_rst_counts");
    gen(8'h6D, 1'b1);
    tick();
    rst = 1'b1;
    player_press = 1'b1;
    tick();
    check("mrst_disp", display_seg, 8'hFF);
    check("mrst_win", window_open, 1'b0);
    check("mrst_flash", hit_flash, 1'b0);
    check("mrst_state", dbg_state, ST_IDLE);
    e_hit = 0; e_miss = 0; e_false = 0;
    expect_counts();
    compare_counts("mrst_counts");
    rst = 1'b0;
    player_press = 1'b0;
    tick();

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sym_response_scorer.md
Name: sym_response_scorer

Overview:
- Sits directly downstream of the symbol generator.
- Consumes its one-cycle `generated`/`special` pulse and 8-bit seven-segment pattern, and holds the symbol on the display for a bounded response window.
- Checks the player's button press against that window and keeps 2-digit BCD tallies of hits, misses and false presses for the score display stage.
- One FSM, a window timer, a flash timer and three saturating BCD counters.

Parameters:
- WINDOW_CYCLES, 50000000, length of the response window in clocks (0.5 s at 100 MHz); minimum 2.
- FLASH_CYCLES, 10000000, length of the hitFlash indication in clocks; minimum 1.

Ports:
- Clk100M  input  1  system clock; all logic on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- gameActive  input  1  game period in progress (same signal that drives the generator's genSym).
- generated  input  1  one-cycle pulse: a new symbol is available.
- special  input  1  qualifies generated: the symbol is the target symbol.
- generatedSym  input  8  active-low seven-segment pattern, valid with generated.
- playerPress  input  1  debounced, single-cycle button press pulse.
- displaySeg  output  8  active-low segment pattern to drive; 8'hFF = blank.
- windowOpen  output  1  high while a response window is open.
- hitFlash  output  1  high for FLASH_CYCLES after a hit.
- hitCount  output  8  two BCD digits {tens,ones}, 0–99.
- missCount  output  8  two BCD digits, 0–99.
- falseCount  output  8  two BCD digits, 0–99.

Behaviour:
- Reset (sampled high on a clock edge): state IDLE; displaySeg=8'hFF; windowOpen=0; hitFlash=0; all counts=8'h00; window timer=0; pressed flag=0. Reset applied mid-window takes effect on the next edge with no count updates that cycle.
- All outputs are registered. Latency from generated to displaySeg/windowOpen is 1 cycle. Latency from playerPress to a count change is 1 cycle.
- IDLE:
  - displaySeg=8'hFF, windowOpen=0.
  - generated & gameActive → SHOW. Latch generatedSym into displaySeg and special into specLatch; clear timer and pressed flag.
  - playerPress & gameActive → falseCount+1.
- SHOW:
  - Timer increments each cycle.
  - playerPress with pressed=0: if specLatch, hitCount+1 and hitFlash restarts for FLASH_CYCLES; else falseCount+1. Set pressed=1.
  - playerPress with pressed=1 is ignored (no count).
  - Window end, when timer reaches WINDOW_CYCLES-1:
    - If specLatch & !pressed & no press this cycle → missCount+1.
    - → IDLE, display blanked next cycle.
- Simultaneous events:
  - Press in the window's last cycle counts as a response in that window (hit or false); no miss is counted.
  - generated during SHOW closes the current window immediately, with a same-cycle press evaluated first and miss rules applied as at window end. It then opens a new window with the new symbol, staying in SHOW with timer=0 and pressed=0.
  - generated without gameActive is ignored.
- gameActive 1→0: → IDLE on the next edge, display blanked, no miss counted for the open window. Counts and hitFlash hold; hitFlash finishes its count.
- gameActive 0→1 (edge detected internally): all three counts cleared to 00 that cycle. Events in the same cycle are evaluated after the clear.
- Counters: BCD with ones wrap 9→0 carrying into tens; saturate at 99 (increment at 99 holds 99).
- hitFlash: a new hit while already high restarts the full FLASH_CYCLES duration.
- Timers are sized $clog2 of their parameter; no arithmetic overflow is permitted.

Decomposition:
- Package sym_pkg:
  - State encoding (IDLE, SHOW).
  - SEG_BLANK=8'hFF.
  - BCD digit width 4 and count width 8.
- Sub-module bcd_sat_counter:
  - Ports: Clk100M, Reset, clr, inc, count[7:0].
  - Two BCD digits, saturating at 99.
  - Instantiated three times for hit, miss and false counts.

Test Plan (WINDOW_CYCLES=10, FLASH_CYCLES=4):
- Reset then gameActive=1; generated=1, special=1, generatedSym=8'hA4; press 3 cycles later → displaySeg=8'hA4 and windowOpen=1 one cycle after generated; hitCount=8'h01; hitFlash high exactly 4 cycles; display 8'hFF after 10 window cycles.
- Special symbol, no press for 10 cycles → missCount=8'h01, windowOpen=0; a non-special symbol with no press → no count changes.
- Non-special symbol with 2 presses in the window, plus 1 press in IDLE → falseCount=8'h02 (the second in-window press is ignored).
- Press on the window's last cycle for a special symbol → hitCount+1, missCount unchanged. A second generated at window cycle 5 of an unpressed special window → missCount+1 and the new symbol is displayed with timer restarted.
- Drive 100 hits → hitCount=8'h99, with 8'h09→8'h10 carry checked. A gameActive 0→1 toggle → all counts 8'h00. gameActive drop mid-window → IDLE next cycle with no miss.
- Reset asserted mid-window with a simultaneous press → all outputs at reset values next cycle, counts 00.
